// File: rtl/load_store_unit.sv
// Load/store unit: turns CPU load/store requests into word-aligned memory
// transactions, splitting misaligned accesses and extending returned load data.
module load_store_unit #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [5:0]  alucode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [5:0] ALU_LB  = 6'd11;
    localparam logic [5:0] ALU_LH  = 6'd12;
    localparam logic [5:0] ALU_LW  = 6'd13;
    localparam logic [5:0] ALU_LBU = 6'd14;
    localparam logic [5:0] ALU_LHU = 6'd15;
    localparam logic [5:0] ALU_SB  = 6'd16;
    localparam logic [5:0] ALU_SH  = 6'd17;
    localparam logic [5:0] ALU_SW  = 6'd18;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACC0  = 3'd1;
    localparam logic [2:0] S_WAIT0 = 3'd2;
    localparam logic [2:0] S_ACC1  = 3'd3;
    localparam logic [2:0] S_WAIT1 = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]  state;
    logic        ld_q, err_q, split_q, hold_err_q;
    logic [5:0]  op_q;
    logic [31:0] addr_q, wdata_q, r0_q, r1_q, hold_data_q;
    logic [3:0]  mask_q;

    logic [2:0]  sz_in;
    logic [3:0]  mask_in;
    logic        ld_op, st_op, legal, mis_in;

    always_comb begin
        sz_in   = 3'd0;
        mask_in = 4'b0000;
        ld_op   = 1'b0;
        st_op   = 1'b0;
        case (alucode)
            ALU_LB, ALU_LBU: begin sz_in = 3'd1; mask_in = 4'b0001; ld_op = 1'b1; end
            ALU_LH, ALU_LHU: begin sz_in = 3'd2; mask_in = 4'b0011; ld_op = 1'b1; end
            ALU_LW:          begin sz_in = 3'd4; mask_in = 4'b1111; ld_op = 1'b1; end
            ALU_SB:          begin sz_in = 3'd1; mask_in = 4'b0001; st_op = 1'b1; end
            ALU_SH:          begin sz_in = 3'd2; mask_in = 4'b0011; st_op = 1'b1; end
            ALU_SW:          begin sz_in = 3'd4; mask_in = 4'b1111; st_op = 1'b1; end
            default: ;
        endcase
        legal  = (is_load && !is_store && ld_op) || (is_store && !is_load && st_op);
        mis_in = ({1'b0, addr[1:0]} + sz_in) > 3'd4;
    end

    logic [1:0]  off;
    logic [4:0]  sh;
    logic [7:0]  m8;
    logic [63:0] d64;
    logic [31:0] base, v, ext, res;
    logic        acc, sel1;

    always_comb begin
        off  = addr_q[1:0];
        sh   = {off, 3'b000};
        m8   = {4'b0000, mask_q} << off;
        d64  = {32'b0, wdata_q} << sh;
        base = {addr_q[31:2], 2'b00};
        acc  = (state == S_ACC0) || (state == S_ACC1);
        sel1 = (state == S_ACC1);
        // Second-word bytes sit above the first in {r1,r0}; r1 stays 0 when unsplit.
        v    = 32'({r1_q, r0_q} >> sh);
        case (op_q)
            ALU_LB:  ext = {{24{v[7]}}, v[7:0]};
            ALU_LBU: ext = {24'b0, v[7:0]};
            ALU_LH:  ext = {{16{v[15]}}, v[15:0]};
            ALU_LHU: ext = {16'b0, v[15:0]};
            ALU_LW:  ext = v;
            default: ext = '0;
        endcase
        res = (err_q || !ld_q) ? '0 : ext;
    end

    assign req_ready  = (state == S_IDLE);
    assign mem_req    = acc;
    assign mem_we     = acc && !ld_q;
    assign mem_addr   = acc ? (sel1 ? base + 32'd4 : base) : '0;
    assign mem_be     = acc ? (sel1 ? m8[7:4] : m8[3:0]) : '0;
    assign mem_wdata  = acc ? (sel1 ? d64[63:32] : d64[31:0]) : '0;
    assign resp_valid = (state == S_DONE);
    assign resp_err   = (state == S_DONE) ? err_q : hold_err_q;
    assign resp_data  = (state == S_DONE) ? res : hold_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            ld_q        <= 1'b0;
            err_q       <= 1'b0;
            split_q     <= 1'b0;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            r0_q        <= '0;
            r1_q        <= '0;
            hold_err_q  <= 1'b0;
            hold_data_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    ld_q    <= is_load;
                    op_q    <= alucode;
                    addr_q  <= addr;
                    wdata_q <= wdata;
                    mask_q  <= mask_in;
                    split_q <= mis_in;
                    r0_q    <= '0;
                    r1_q    <= '0;
                    if (!legal || (mis_in && !SPLIT_EN)) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        err_q <= 1'b0;
                        state <= S_ACC0;
                    end
                end
                S_ACC0: if (mem_gnt)
                    state <= ld_q ? S_WAIT0 : (split_q ? S_ACC1 : S_DONE);
                S_WAIT0: if (mem_rvalid) begin
                    r0_q  <= mem_rdata;
                    state <= split_q ? S_ACC1 : S_DONE;
                end
                S_ACC1: if (mem_gnt)
                    state <= ld_q ? S_WAIT1 : S_DONE;
                S_WAIT1: if (mem_rvalid) begin
                    r1_q  <= mem_rdata;
                    state <= S_DONE;
                end
                S_DONE: begin
                    hold_err_q  <= err_q;
                    hold_data_q <= res;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
